// File: rtl/sram_port_arbiter_pkg.sv
// Shared arbiter definitions: response tag encoding and the default fetch-starvation limit.
package sram_port_arbiter_pkg;

    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_INST = 2'd1,
        TAG_DATA = 2'd2
    } resp_tag_t;

    localparam int STARVE_LIMIT_DEF = 3;
    localparam int DATA_W           = 32;

endpackage

// File: rtl/sram_port_arbiter.sv
// Arbitrates fetch and data requests onto one single-port SRAM; grant is combinational, read response one cycle later.
// No response backpressure; requesters hold their request until granted and must take rvalid when it appears.
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    parameter int ADDR_W       = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              inst_req,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_cancel,
    output logic              inst_gnt,
    output logic              inst_rvalid,
    output logic [DATA_W-1:0] inst_rdata,
    input  logic              data_req,
    input  logic [3:0]        data_we,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_gnt,
    output logic              data_rvalid,
    output logic [DATA_W-1:0] data_rdata,
    output logic              sram_en,
    output logic [3:0]        sram_we,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    input  logic [DATA_W-1:0] sram_rdata
);

    logic [1:0] r_starve_cnt;
    resp_tag_t  r_tag;
    resp_tag_t  w_tag_nxt;
    logic       w_starved;
    logic       w_inst_gnt;
    logic       w_data_gnt;

    assign w_starved = (r_starve_cnt == 2'(STARVE_LIMIT));

    // Data wins ties until the waiting fetch has been passed over STARVE_LIMIT times.
    always_comb begin
        w_inst_gnt = 1'b0;
        w_data_gnt = 1'b0;
        if (resetn) begin
            if (data_req && !(inst_req && w_starved)) begin
                w_data_gnt = 1'b1;
            end else if (inst_req) begin
                w_inst_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        w_tag_nxt = TAG_NONE;
        if (w_inst_gnt && !inst_cancel) begin
            w_tag_nxt = TAG_INST;
        end else if (w_data_gnt && (data_we == 4'h0)) begin
            w_tag_nxt = TAG_DATA;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_tag        <= TAG_NONE;
            r_starve_cnt <= 2'd0;
        end else begin
            r_tag <= w_tag_nxt;
            if (w_inst_gnt || !inst_req) begin
                r_starve_cnt <= 2'd0;
            end else if (w_data_gnt && !w_starved && (r_starve_cnt != 2'd3)) begin
                r_starve_cnt <= r_starve_cnt + 2'd1;
            end
        end
    end

    assign inst_gnt   = w_inst_gnt;
    assign data_gnt   = w_data_gnt;
    assign sram_en    = w_inst_gnt | w_data_gnt;
    assign sram_we    = w_data_gnt ? data_we : 4'h0;
    assign sram_wdata = w_data_gnt ? data_wdata : '0;
    assign sram_addr  = w_data_gnt ? data_addr : (w_inst_gnt ? inst_addr : '0);

    // A cancel also kills the fetch response already on its way back this cycle.
    assign inst_rvalid = (r_tag == TAG_INST) && !inst_cancel;
    assign inst_rdata  = inst_rvalid ? sram_rdata : '0;
    assign data_rvalid = (r_tag == TAG_DATA);
    assign data_rdata  = data_rvalid ? sram_rdata : '0;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Scoreboard bench: stimulus pushes predicted responses, an independent monitor pops and compares them.
module tb_sram_port_arbiter;
    import sram_port_arbiter_pkg::*;

    localparam int LIM = STARVE_LIMIT_DEF;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        inst_req = 1'b0, inst_cancel = 1'b0, data_req = 1'b0;
    logic [31:0] inst_addr = '0, data_addr = '0, data_wdata = '0;
    logic [3:0]  data_we = '0;
    logic        inst_gnt, inst_rvalid, data_gnt, data_rvalid, sram_en;
    logic [31:0] inst_rdata, data_rdata, sram_addr, sram_wdata;
    logic [31:0] sram_rdata = '0;
    logic [3:0]  sram_we;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    sram_port_arbiter #(.STARVE_LIMIT(LIM), .ADDR_W(32)) dut (
        .clk(clk), .resetn(resetn),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_cancel(inst_cancel),
        .inst_gnt(inst_gnt), .inst_rvalid(inst_rvalid), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_we(data_we), .data_addr(data_addr), .data_wdata(data_wdata),
        .data_gnt(data_gnt), .data_rvalid(data_rvalid), .data_rdata(data_rdata),
        .sram_en(sram_en), .sram_we(sram_we), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
    );

    // 256-word SRAM environment; upper address bits are ignored.
    logic [31:0] sram_mem [0:255];
    always @(posedge clk) begin
        if (sram_en) begin
            if (sram_we == 4'h0) begin
                sram_rdata <= sram_mem[sram_addr[9:2]];
            end else begin
                for (int b = 0; b < 4; b++)
                    if (sram_we[b]) sram_mem[sram_addr[9:2]][8*b +: 8] <= sram_wdata[8*b +: 8];
            end
        end
    end

    // Reference model state
    logic [31:0] ref_mem [0:255];
    int          m_wait = 0;
    typedef struct { int due; logic [31:0] dat; } exp_t;
    exp_t inst_q[$];
    exp_t data_q[$];

    int vectors = 0;
    int errors  = 0;

    function automatic logic [31:0] init_word(int i);
        return 32'h5A00_0000 ^ (32'(i) * 32'h0101_0107);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic step(input logic rn, input logic ir, input logic [31:0] ia, input logic ic,
                        input logic dr, input logic [3:0] dwe, input logic [31:0] da,
                        input logic [31:0] dwd, input byte pat, output logic gi, output logic gd);
        logic [1:0] pexp;
        @(negedge clk);
        resetn = rn; inst_req = ir; inst_addr = ia; inst_cancel = ic;
        data_req = dr; data_we = dwe; data_addr = da; data_wdata = dwd;
        gi = 1'b0;
        gd = 1'b0;
        if (rn) begin
            if (ir && (!dr || m_wait >= LIM)) gi = 1'b1;
            else if (dr) gd = 1'b1;
        end
        if (ic) while (inst_q.size() > 0 && inst_q[0].due == cyc) void'(inst_q.pop_front());
        #1;
        chk("inst_gnt", 32'(inst_gnt), 32'(gi));
        chk("data_gnt", 32'(data_gnt), 32'(gd));
        chk("sram_en", 32'(sram_en), 32'(gi | gd));
        chk("sram_we", 32'(sram_we), 32'(gd ? dwe : 4'h0));
        chk("sram_wdata", sram_wdata, gd ? dwd : 32'h0);
        if (gi || gd) chk("sram_addr", sram_addr, gd ? da : ia);
        if (pat != 0) begin
            pexp = (pat == "I") ? 2'b10 : (pat == "D") ? 2'b01 : 2'b00;
            chk("grant_pattern", 32'({inst_gnt, data_gnt}), 32'(pexp));
        end
        if (gi && !ic) inst_q.push_back('{cyc + 1, ref_mem[ia[9:2]]});
        if (gd && dwe == 4'h0) data_q.push_back('{cyc + 1, ref_mem[da[9:2]]});
        if (gd && dwe != 4'h0)
            for (int b = 0; b < 4; b++)
                if (dwe[b]) ref_mem[da[9:2]][8*b +: 8] = dwd[8*b +: 8];
        if (!rn || gi || !ir) m_wait = 0;
        else if (gd && m_wait < LIM) m_wait++;
    endtask

    // Monitor
    initial begin
        logic ev;
        forever begin
            @(negedge clk);
            #2;
            ev = (inst_q.size() > 0) && (inst_q[0].due == cyc);
            chk("inst_rvalid", 32'(inst_rvalid), 32'(ev));
            if (ev) begin
                if (inst_rvalid) chk("inst_rdata", inst_rdata, inst_q[0].dat);
                void'(inst_q.pop_front());
            end else if (!inst_rvalid) chk("inst_rdata_idle", inst_rdata, 32'h0);
            ev = (data_q.size() > 0) && (data_q[0].due == cyc);
            chk("data_rvalid", 32'(data_rvalid), 32'(ev));
            if (ev) begin
                if (data_rvalid) chk("data_rdata", data_rdata, data_q[0].dat);
                void'(data_q.pop_front());
            end else if (!data_rvalid) chk("data_rdata_idle", data_rdata, 32'h0);
        end
    end

    initial begin
        logic gi, gd;
        logic ip, dp, ic;
        logic [31:0] ia, da, dwd;
        logic [3:0]  dwe;
        string pat_s;
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = init_word(i);
            ref_mem[i]  = init_word(i);
        end

        // Reset with both requesters active: nothing may be granted.
        for (int k = 0; k < 3; k++) step(0, 1, 32'h40, 0, 1, 4'h0, 32'h44, 0, "-", gi, gd);

        // Single fetch
        step(1, 1, 32'h1c00_0000, 0, 0, 4'h0, 0, 0, "I", gi, gd);
        step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);

        // Contention with a waiting fetch
        pat_s = "DDDIDD";
        for (int k = 0; k < 6; k++)
            step(1, 1, 32'h1c00_0004, 0, 1, 4'h0, 32'h40 + 32'(4 * k), 0, pat_s[k], gi, gd);
        step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);

        // Write then read back
        step(1, 0, 0, 0, 1, 4'hF, 32'h100, 32'hDEAD_BEEF, "D", gi, gd);
        step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);
        step(1, 0, 0, 0, 1, 4'h0, 32'h100, 0, "D", gi, gd);
        step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);

        // Cancel the cycle after a fetch grant, then cancel a same-cycle grant
        step(1, 1, 32'h8, 0, 0, 4'h0, 0, 0, "I", gi, gd);
        step(1, 0, 0, 1, 0, 4'h0, 0, 0, "-", gi, gd);
        step(1, 1, 32'hC, 1, 0, 4'h0, 0, 0, "I", gi, gd);
        step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);

        // Alternating fetch / data reads
        for (int k = 0; k < 6; k++)
            step(1, k[0] == 1'b0, 32'h20 + 32'(4 * k), 0, k[0] == 1'b1, 4'h0, 32'h80 + 32'(4 * k), 0,
                 (k[0] == 1'b0) ? "I" : "D", gi, gd);

        // Reset with a read requested and a partially built starvation count
        step(1, 1, 32'h30, 0, 1, 4'h0, 32'h34, 0, "D", gi, gd);
        step(1, 1, 32'h30, 0, 1, 4'h0, 32'h38, 0, "D", gi, gd);
        step(0, 1, 32'h30, 0, 1, 4'h0, 32'h3C, 0, "-", gi, gd);
        pat_s = "DDDI";
        for (int k = 0; k < 4; k++)
            step(1, 1, 32'h30, 0, 1, 4'h0, 32'h50 + 32'(4 * k), 0, pat_s[k], gi, gd);

        // Randomized traffic with held requests
        ip = 1'b0; dp = 1'b0; ia = '0; da = '0; dwd = '0; dwe = '0;
        for (int n = 0; n < 400; n++) begin
            if (!ip && $urandom_range(0, 1) == 1) begin
                ip = 1'b1;
                ia = 32'($urandom_range(0, 63)) << 2;
            end
            if (!dp && $urandom_range(0, 1) == 1) begin
                dp  = 1'b1;
                da  = 32'($urandom_range(0, 63)) << 2;
                dwd = $urandom;
                dwe = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(1, 15)) : 4'h0;
            end
            ic = ($urandom_range(0, 7) == 0);
            step($urandom_range(0, 39) != 0, ip, ia, ic, dp, dwe, da, dwd, 0, gi, gd);
            if (gi) ip = 1'b0;
            if (gd) dp = 1'b0;
        end

        for (int k = 0; k < 3; k++) step(1, 0, 0, 0, 0, 4'h0, 0, 0, "-", gi, gd);
        chk("drain", 32'(inst_q.size() + data_q.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
